// File: rtl/oscillator_phase_if.sv
// Bundle between the note/pitch controller and the phase generator.
// The controller side drives enable, note gate and divider; the phase
// generator returns the sawtooth phase, its step pulse and the run flag.
interface oscillator_phase_if #(
  parameter int DIV_WIDTH   = 16,
  parameter int PHASE_WIDTH = 8
);
  logic                   en;
  logic                   note_valid;
  logic [DIV_WIDTH-1:0]   divider;
  logic [PHASE_WIDTH-1:0] quotient;
  logic                   phase_tick;
  logic                   active;

  modport master (
    output en, note_valid, divider,
    input  quotient, phase_tick, active
  );

  modport slave (
    input  en, note_valid, divider,
    output quotient, phase_tick, active
  );
endinterface

// File: rtl/oscillator_phase.sv
// Sawtooth phase generator feeding the waveshaper. A clock-divide counter
// advances the 8-bit phase once every div_q enabled clocks. The latched
// divider is only refreshed on the 255 -> 0 wrap so pitch changes never
// cut a waveform period short. Dropping the note (or a zero divider)
// aborts to IDLE with the phase cleared.
module oscillator_phase #(
  parameter int DIV_WIDTH   = 16,
  parameter int PHASE_WIDTH = 8
) (
  input  logic           clk,
  input  logic           n_rst,
  oscillator_phase_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [DIV_WIDTH-1:0]   DIV_ZERO   = {DIV_WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0]   DIV_ONE    = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PHASE_WIDTH-1:0] PHASE_ZERO = {PHASE_WIDTH{1'b0}};
  localparam logic [PHASE_WIDTH-1:0] PHASE_ONE  = {{(PHASE_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PHASE_WIDTH-1:0] PHASE_MAX  = {PHASE_WIDTH{1'b1}};

  state_t                 state;
  state_t                 state_nxt;
  logic [DIV_WIDTH-1:0]   count;
  logic [DIV_WIDTH-1:0]   count_nxt;
  logic [DIV_WIDTH-1:0]   div_q;
  logic [DIV_WIDTH-1:0]   div_nxt;
  logic [PHASE_WIDTH-1:0] phase;
  logic [PHASE_WIDTH-1:0] phase_nxt;
  logic                   tick;
  logic                   tick_nxt;
  logic                   act;
  logic                   act_nxt;

  // A note can start only with a non-zero divider; a running note stops
  // when released or when the latched divider is zero.
  logic start;
  logic abort;
  logic step;

  assign start = bus.note_valid && (bus.divider != DIV_ZERO);
  assign abort = !bus.note_valid || (div_q == DIV_ZERO);
  assign step  = (count == (div_q - DIV_ONE));

  // State register plus registered datapath and outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      count <= DIV_ZERO;
      div_q <= DIV_ZERO;
      phase <= PHASE_ZERO;
      tick  <= 1'b0;
      act   <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      div_q <= div_nxt;
      phase <= phase_nxt;
      tick  <= tick_nxt;
      act   <= act_nxt;
    end
  end

  // Next-state selection; a low enable freezes the FSM.
  always_comb begin
    state_nxt = state;
    if (!bus.en) begin
      state_nxt = state;
    end else begin
      case (state)
        IDLE: begin
          if (start) state_nxt = RUN;
          else       state_nxt = IDLE;
        end
        RUN: begin
          if (abort) state_nxt = IDLE;
          else       state_nxt = RUN;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath and output next values; abort wins over stepping.
  always_comb begin
    count_nxt = count;
    div_nxt   = div_q;
    phase_nxt = phase;
    tick_nxt  = 1'b0;
    if (!bus.en) begin
      count_nxt = count;
      div_nxt   = div_q;
      phase_nxt = phase;
    end else begin
      case (state)
        IDLE: begin
          count_nxt = DIV_ZERO;
          phase_nxt = PHASE_ZERO;
          if (start) div_nxt = bus.divider;
          else       div_nxt = div_q;
        end
        RUN: begin
          if (abort) begin
            count_nxt = DIV_ZERO;
            phase_nxt = PHASE_ZERO;
          end else if (step) begin
            count_nxt = DIV_ZERO;
            phase_nxt = phase + PHASE_ONE;
            tick_nxt  = 1'b1;
            // New pitch takes effect only at the start of a fresh period.
            if (phase == PHASE_MAX) div_nxt = bus.divider;
            else                    div_nxt = div_q;
          end else begin
            count_nxt = count + DIV_ONE;
          end
        end
        default: begin
          count_nxt = DIV_ZERO;
          div_nxt   = DIV_ZERO;
          phase_nxt = PHASE_ZERO;
        end
      endcase
    end
    act_nxt = (state_nxt == RUN);
  end

  assign bus.quotient   = phase;
  assign bus.phase_tick = tick;
  assign bus.active     = act;

endmodule

// File: doc/oscillator_phase.md
Name: oscillator_phase

Overview:
Phase generator directly upstream of the waveshaper. It turns a per-note clock divider into the 8-bit sawtooth phase `quotient` that the waveshaper maps to a sample. One full phase cycle lasts 256 × divider clocks. Pitch changes are applied only at phase wrap, so waveforms stay glitch-free. The block gates silence when no note is held.

Parameters:
DIV_WIDTH, 16, width of the divider input and the internal clock-divide counter.
PHASE_WIDTH, 8, width of the phase output; fixed at 8 to match the waveshaper `quotient` input.

Ports:
clk  input  1  system clock; all state updates on rising edge.
n_rst  input  1  asynchronous active-low reset.
en  input  1  global clock enable; low freezes all counters and outputs.
note_valid  input  1  high while a note is held.
divider  input  DIV_WIDTH  clocks per phase step for the current note; 0 means silence.
quotient  output  PHASE_WIDTH  current phase, feeds the waveshaper.
phase_tick  output  1  one-cycle pulse in the cycle `quotient` takes a new incremented value.
active  output  1  high while in state RUN.

Behaviour:
- Reset (n_rst low, asynchronous):
  - state = IDLE; quotient = 0; count = 0; div_q = 0; phase_tick = 0; active = 0.
  - Reset takes effect immediately, including mid-RUN.
- All outputs are registered. No combinational path from any input to any output.
- en = 0 (any state): state, count, quotient and div_q hold their values; phase_tick = 0.
  - en = 0 overrides note_valid changes until en returns high.
- IDLE, with en = 1:
  - quotient = 0, count = 0, phase_tick = 0, active = 0.
  - If note_valid = 1 and divider != 0 at a rising edge: div_q <= divider, count <= 0, state <= RUN. active is high from the next cycle.
- RUN, with en = 1:
  - If note_valid = 0 or div_q == 0: state <= IDLE, quotient <= 0, count <= 0, phase_tick <= 0. This is a one-edge abort, taking priority over stepping.
  - Else if count == div_q − 1: count <= 0, quotient <= quotient + 1 (modulo 256, so 255 → 0), phase_tick <= 1.
  - Else: count <= count + 1, phase_tick <= 0.
- Divider update:
  - While in RUN, `divider` is sampled into div_q only on the step where quotient wraps from 255 to 0.
  - Changes at any other time are ignored until the next wrap.
  - If the sampled divider is 0, the next edge moves to IDLE under the abort rule.
- Timing:
  - Entering RUN at edge N means quotient becomes 1 at edge N + D, 2 at N + 2D, and so on.
  - The wrap to 0 occurs at edge N + 256·D.
  - divider = 1 gives one increment per enabled clock, with phase_tick held high continuously.
- Re-trigger: note_valid dropping and rising again always passes through IDLE, so phase restarts from 0.
- count is DIV_WIDTH bits wide and never exceeds div_q − 1.

Test Plan:
- Reset: assert n_rst low mid-RUN with quotient = 0x5A → quotient, active and phase_tick go to 0 immediately; all stay 0 after release until note_valid is high.
- Basic step: divider = 4, note_valid high at edge 0 → active = 1 from cycle 1; quotient increments at edges 4, 8, 12…; phase_tick is high exactly one cycle per increment; quotient is 0 again at edge 1024.
- Divider = 1: quotient increments every cycle; 0xFF → 0x00 wraps after 256 cycles; phase_tick stays constantly high.
- Deferred pitch change: start with divider = 3, change to 5 when quotient = 0x10 → step spacing stays 3 until the 255 → 0 wrap, then becomes 5.
- Enable freeze: en low for 10 cycles at quotient = 0x20, count = 1 → all values hold and phase_tick = 0; stepping resumes with the same count once en returns high.
- Silence and abort:
  - note_valid = 1 with divider = 0 in IDLE → stays IDLE with quotient = 0.
  - Drop note_valid mid-RUN → IDLE at the next edge with quotient = 0.
  - Re-press → phase restarts from 0.
